// File: rtl/cpu24_pkg.sv
// Shared definitions for the 24-bit CPU: instruction fields, opcodes and
// the fetch-unit state type.
package cpu24_pkg;

  localparam int INSTR_W = 24;

  localparam int OPC_MSB = 23;
  localparam int OPC_LSB = 20;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_LS    = 4'b0010;
  localparam logic [3:0] OP_SS    = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_RTYPE = 4'b0110;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    TRAP
  } fetchState_t;

  function automatic logic isLegalOpcode(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_LS) || (op == OP_SS) ||
           (op == OP_BEQ)  || (op == OP_RTYPE);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory port plus the decoder/datapath side of the fetch unit.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 16
);

  logic                         imemReq;
  logic [ADDR_W-1:0]            imemAddr;
  logic                         imemAck;
  logic [cpu24_pkg::INSTR_W-1:0] imemRdata;
  logic [cpu24_pkg::INSTR_W-1:0] instr;
  logic [3:0]                   opcode;
  logic [ADDR_W-1:0]            pc;
  logic                         instrValid;
  logic                         instrAccept;
  logic                         branch;
  logic                         zero;
  logic                         illegal;
  logic                         busErr;

  modport master (
    output imemReq, imemAddr, instr, opcode, pc, instrValid, illegal, busErr,
    input  imemAck, imemRdata, instrAccept, branch, zero
  );

  modport slave (
    input  imemReq, imemAddr, instr, opcode, pc, instrValid, illegal, busErr,
    output imemAck, imemRdata, instrAccept, branch, zero
  );

endinterface

// File: rtl/pc_next_calc.sv
// Next fetch address: PC + 1, plus the sign-extended immediate when taken.
module pc_next_calc #(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [15:0]       imm,
  input  logic              taken,
  output logic [ADDR_W-1:0] nextPc
);

  logic [31:0] immExt;

  // Extension to 32 bits then truncation covers both wider and narrower PCs.
  assign immExt = {{16{imm[15]}}, imm};
  assign nextPc = pc + ADDR_W'(1) + (taken ? immExt[ADDR_W-1:0] : {ADDR_W{1'b0}});

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch FSM: requests a word, checks its opcode, holds it until the datapath
// accepts it, then redirects the PC; traps on illegal opcodes or ACK timeout.
module instr_fetch_unit
  import cpu24_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  instr_fetch_unit_if.master bus
);

  fetchState_t          stateReg;
  logic [ADDR_W-1:0]    fetchPcReg;
  logic [ADDR_W-1:0]    pcReg;
  logic [INSTR_W-1:0]   instrReg;
  logic                 reqReg;
  logic                 validReg;
  logic                 illegalReg;
  logic                 busErrReg;
  logic [7:0]           waitCntReg;
  logic [ADDR_W-1:0]    nextPc;

  pc_next_calc #(.ADDR_W(ADDR_W)) uNextPc (
    .pc     (pcReg),
    .imm    (instrReg[IMM_MSB:IMM_LSB]),
    .taken  (bus.branch & bus.zero),
    .nextPc (nextPc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg   <= IDLE;
      fetchPcReg <= RESET_PC;
      pcReg      <= RESET_PC;
      instrReg   <= '0;
      reqReg     <= 1'b0;
      validReg   <= 1'b0;
      illegalReg <= 1'b0;
      busErrReg  <= 1'b0;
      waitCntReg <= '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (en) begin
            stateReg   <= FETCH;
            reqReg     <= 1'b1;
            waitCntReg <= '0;
          end
        end
        FETCH: begin
          if (bus.imemAck) begin
            instrReg   <= bus.imemRdata;
            pcReg      <= fetchPcReg;
            waitCntReg <= '0;
            reqReg     <= 1'b0;
            if (isLegalOpcode(bus.imemRdata[OPC_MSB:OPC_LSB])) begin
              stateReg <= ISSUE;
              validReg <= 1'b1;
            end else begin
              stateReg   <= TRAP;
              illegalReg <= 1'b1;
            end
          end else begin
            waitCntReg <= waitCntReg + 8'd1;
            // Last allowed waiting cycle passed without ACK.
            if (waitCntReg == 8'(TIMEOUT - 1)) begin
              stateReg  <= TRAP;
              reqReg    <= 1'b0;
              busErrReg <= 1'b1;
              pcReg     <= fetchPcReg;
            end
          end
        end
        ISSUE: begin
          if (bus.instrAccept) begin
            validReg   <= 1'b0;
            fetchPcReg <= nextPc;
            if (en) begin
              stateReg <= FETCH;
              reqReg   <= 1'b1;
            end else begin
              stateReg <= IDLE;
            end
          end
        end
        TRAP:    stateReg <= TRAP;
        default: stateReg <= IDLE;
      endcase
    end
  end

  assign bus.imemReq    = reqReg;
  assign bus.imemAddr   = fetchPcReg;
  assign bus.instr      = instrReg;
  assign bus.opcode     = instrReg[OPC_MSB:OPC_LSB];
  assign bus.pc         = pcReg;
  assign bus.instrValid = validReg;
  assign bus.illegal    = illegalReg;
  assign bus.busErr     = busErrReg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized checks of instr_fetch_unit against a cycle-level
// behavioural model of fetch / issue / trap.
module tb_instr_fetch_unit;

  localparam int          AW  = 16;
  localparam logic [15:0] RPC = 16'h0010;
  localparam int          TO  = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(AW)) bus();

  instr_fetch_unit #(.ADDR_W(AW), .RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model
  bit          mFetching, mIssuing, mIll, mBus;
  int          mWait;
  logic [15:0] mFetch, mPc;
  logic [23:0] mInstr;

  function automatic bit legalOp(input logic [3:0] op);
    return (op == 4'd1) || (op == 4'd2) || (op == 4'd3) || (op == 4'd4) || (op == 4'd6);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mFetching = 0; mIssuing = 0; mIll = 0; mBus = 0; mWait = 0;
    mFetch = RPC; mPc = RPC; mInstr = '0;
  endtask

  task automatic compareAll();
    check("imemReq",    32'(bus.imemReq),    32'(mFetching));
    check("imemAddr",   32'(bus.imemAddr),   32'(mFetch));
    check("instrValid", 32'(bus.instrValid), 32'(mIssuing));
    check("instr",      32'(bus.instr),      32'(mInstr));
    check("opcode",     32'(bus.opcode),     32'(mInstr[23:20]));
    check("pc",         32'(bus.pc),         32'(mPc));
    check("illegal",    32'(bus.illegal),    32'(mIll));
    check("busErr",     32'(bus.busErr),     32'(mBus));
  endtask

  // One clock: check current outputs, drive inputs, advance model, move to next negedge.
  task automatic doCycle(input bit e, input bit ack, input logic [23:0] rd,
                         input bit acc, input bit br, input bit z);
    int          t;
    logic [15:0] imm;
    compareAll();
    en              = e;
    bus.imemAck     = ack;
    bus.imemRdata   = rd;
    bus.instrAccept = acc;
    bus.branch      = br;
    bus.zero        = z;
    if (mIll || mBus) begin
      // trapped until reset
    end else if (mFetching) begin
      if (ack) begin
        mPc = mFetch; mInstr = rd; mWait = 0; mFetching = 0;
        if (legalOp(rd[23:20])) mIssuing = 1;
        else                    mIll = 1;
      end else begin
        mWait++;
        if (mWait == TO) begin
          mBus = 1; mPc = mFetch; mFetching = 0;
        end
      end
    end else if (mIssuing) begin
      if (acc) begin
        imm = mInstr[15:0];
        t = int'(mPc) + 1 + ((br && z) ? int'($signed(imm)) : 0);
        mFetch = 16'(t);
        mIssuing = 0;
        mFetching = e;
        mWait = 0;
      end
    end else if (e) begin
      mFetching = 1; mWait = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit   stall;
    int   trapCycles;
    logic [3:0] op;
    logic [3:0] legalList [5];
    legalList[0] = 4'd1; legalList[1] = 4'd2; legalList[2] = 4'd3;
    legalList[3] = 4'd4; legalList[4] = 4'd6;

    bus.imemAck = 0; bus.imemRdata = '0; bus.instrAccept = 0;
    bus.branch = 0; bus.zero = 0;
    @(negedge clk);
    doReset();

    // Reset state, pinned to literals
    check("rst_req",   32'(bus.imemReq),    32'h0);
    check("rst_addr",  32'(bus.imemAddr),   32'h0010);
    check("rst_pc",    32'(bus.pc),         32'h0010);
    check("rst_valid", 32'(bus.instrValid), 32'h0);
    check("rst_instr", 32'(bus.instr),      32'h0);

    // First fetch latency
    doCycle(1, 0, 24'h0, 0, 0, 0);
    check("first_req",   32'(bus.imemReq),    32'h1);
    check("first_addr",  32'(bus.imemAddr),   32'h0010);
    check("first_valid", 32'(bus.instrValid), 32'h0);
    doCycle(1, 1, 24'h1ABCDE, 0, 0, 0);
    check("issue_valid", 32'(bus.instrValid), 32'h1);
    check("issue_op",    32'(bus.opcode),     32'h1);
    check("issue_pc",    32'(bus.pc),         32'h0010);

    // Datapath stall: outputs hold, no new request
    for (int i = 0; i < 5; i++) begin
      doCycle(1, 0, 24'h0, 0, 0, 0);
      check("hold_instr", 32'(bus.instr),   32'h1ABCDE);
      check("hold_req",   32'(bus.imemReq), 32'h0);
    end
    doCycle(1, 0, 24'h0, 1, 0, 0);
    check("seq_addr", 32'(bus.imemAddr), 32'h0011);

    // Walk to 0x0020 then exercise BEQ taken / not taken
    doCycle(1, 1, 24'h10000E, 0, 0, 0);
    doCycle(1, 0, 24'h0, 1, 1, 1);
    check("to_20", 32'(bus.imemAddr), 32'h0020);
    doCycle(1, 1, 24'h40FFFE, 0, 0, 0);
    doCycle(1, 0, 24'h0, 1, 1, 1);
    check("beq_taken", 32'(bus.imemAddr), 32'h001F);
    doCycle(1, 1, 24'h100000, 0, 0, 0);
    doCycle(1, 0, 24'h0, 1, 0, 0);
    doCycle(1, 1, 24'h40FFFE, 0, 0, 0);
    doCycle(1, 0, 24'h0, 1, 1, 0);
    check("beq_not_taken", 32'(bus.imemAddr), 32'h0021);

    // Wrap-around at the top of the address space
    doCycle(1, 1, 24'h10FFDD, 0, 0, 0);
    doCycle(1, 0, 24'h0, 1, 1, 1);
    check("to_ffff", 32'(bus.imemAddr), 32'hFFFF);
    doCycle(1, 1, 24'h200000, 0, 0, 0);
    doCycle(1, 0, 24'h0, 1, 0, 0);
    check("wrap_0", 32'(bus.imemAddr), 32'h0000);
    doCycle(1, 1, 24'h600004, 0, 0, 0);
    doCycle(1, 0, 24'h0, 1, 1, 1);
    check("to_5", 32'(bus.imemAddr), 32'h0005);

    // Illegal opcode trap
    doCycle(1, 1, 24'hF12345, 0, 0, 0);
    check("ill_flag",  32'(bus.illegal),    32'h1);
    check("ill_valid", 32'(bus.instrValid), 32'h0);
    check("ill_pc",    32'(bus.pc),         32'h0005);
    for (int i = 0; i < 4; i++) begin
      doCycle(1, 0, 24'h0, 1, 0, 0);
      check("ill_noreq", 32'(bus.imemReq), 32'h0);
    end

    // ACK timeout
    doReset();
    doCycle(1, 0, 24'h0, 0, 0, 0);
    for (int i = 0; i < 14; i++) doCycle(1, 0, 24'h0, 0, 0, 0);
    check("to_before", 32'(bus.busErr),  32'h0);
    check("to_stillreq", 32'(bus.imemReq), 32'h1);
    doCycle(1, 0, 24'h0, 0, 0, 0);
    check("to_err", 32'(bus.busErr),  32'h1);
    check("to_pc",  32'(bus.pc),      32'h0010);
    check("to_req", 32'(bus.imemReq), 32'h0);

    // ACK on the final allowed cycle succeeds
    doReset();
    doCycle(1, 0, 24'h0, 0, 0, 0);
    for (int i = 0; i < 14; i++) doCycle(1, 0, 24'h0, 0, 0, 0);
    doCycle(1, 1, 24'h312345, 0, 0, 0);
    check("late_ack_valid", 32'(bus.instrValid), 32'h1);
    check("late_ack_noerr", 32'(bus.busErr),     32'h0);

    // Reset asserted mid-fetch drops the request without a clock edge
    doCycle(1, 0, 24'h0, 1, 0, 0);
    check("mid_req", 32'(bus.imemReq), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(bus.imemReq), 32'h0);
    doReset();

    // Randomized run
    stall = 0;
    trapCycles = 0;
    for (int n = 0; n < 3000; n++) begin
      bit e, ack, acc, br, z;
      logic [23:0] rd;
      if (!mFetching && ($urandom % 40 == 0)) stall = ~stall;
      e = ($urandom % 8) != 0;
      if (mFetching) ack = stall ? ($urandom % 20 == 0) : ($urandom % 3 == 0);
      else           ack = ($urandom % 4 == 0);
      op = legalList[$urandom % 5];
      if ($urandom % 40 == 0) op = 4'($urandom);
      rd = {op, 20'($urandom)};
      acc = $urandom % 2;
      br  = $urandom % 2;
      z   = $urandom % 2;
      doCycle(e, ack, rd, acc, br, z);
      if (mIll || mBus) begin
        trapCycles++;
        if (trapCycles > 5) begin
          compareAll();
          doReset();
          trapCycles = 0;
          stall = 0;
        end
      end
    end
    compareAll();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
